// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : Instruction-fetch stage of the 16-bit MIPS pipeline. Holds the
//            PC and a word-addressed instruction memory, and drives the IF/ID
//            pipeline register towards decode.
// Revision : 1.0  initial release
// ============================================================================
module if_stage #(
    parameter int          ADDR_W = 8,
    parameter logic [15:0] NOP    = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              pcsrc,
    input  logic [15:0]       branch_target,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [15:0]       imem_wdata,
    output logic [15:0]       pc,
    output logic [15:0]       instout,
    output logic [15:0]       branch_adder_out,
    output logic              valid,
    output logic [15:0]       fetch_count
);

    localparam int          c_depth     = 1 << ADDR_W;
    localparam logic [15:0] c_count_max = 16'hFFFF;

    logic [15:0] r_imem [c_depth];

    logic [15:0] r_pc_q,    w_pc_d;
    logic [15:0] r_inst_q,  w_inst_d;
    logic [15:0] r_bao_q,   w_bao_d;
    logic        r_valid_q, w_valid_d;
    logic [15:0] r_fcnt_q,  w_fcnt_d;

    logic [15:0] w_fetch_word;
    logic [15:0] w_pc_inc;

    // Upper PC bits are dropped so the fetch address aliases modulo the depth.
    assign w_fetch_word = r_imem[r_pc_q[ADDR_W-1:0]];
    assign w_pc_inc     = r_pc_q + 16'd1;

    always_comb begin
        w_pc_d    = r_pc_q;
        w_inst_d  = r_inst_q;
        w_bao_d   = r_bao_q;
        w_valid_d = r_valid_q;
        w_fcnt_d  = r_fcnt_q;
        if (pcsrc) begin
            // A redirect wins over a stall and leaves exactly one bubble.
            w_pc_d    = branch_target;
            w_inst_d  = NOP;
            w_bao_d   = 16'h0000;
            w_valid_d = 1'b0;
        end else if (!stall) begin
            w_pc_d    = w_pc_inc;
            w_inst_d  = w_fetch_word;
            w_bao_d   = w_pc_inc;
            w_valid_d = 1'b1;
            if (r_fcnt_q != c_count_max) begin
                w_fcnt_d = r_fcnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_q    <= 16'h0000;
            r_inst_q  <= NOP;
            r_bao_q   <= 16'h0000;
            r_valid_q <= 1'b0;
            r_fcnt_q  <= 16'h0000;
        end else begin
            r_pc_q    <= w_pc_d;
            r_inst_q  <= w_inst_d;
            r_bao_q   <= w_bao_d;
            r_valid_q <= w_valid_d;
            r_fcnt_q  <= w_fcnt_d;
        end
    end

    // Write port is independent of reset/stall/redirect; contents survive reset.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            r_imem[imem_waddr] <= imem_wdata;
        end
    end

    assign pc               = r_pc_q;
    assign instout          = r_inst_q;
    assign branch_adder_out = r_bao_q;
    assign valid            = r_valid_q;
    assign fetch_count      = r_fcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Self-checking bench for if_stage: directed vector table, forced
//            counter saturation, and randomized run against a reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset, stall, pcsrc, imem_we;
    logic [15:0] branch_target, imem_wdata;
    logic [7:0]  imem_waddr;
    logic [15:0] pc, instout, branch_adder_out, fetch_count;
    logic        valid;

    if_stage #(.ADDR_W(8), .NOP(16'h0000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pcsrc(pcsrc),
        .branch_target(branch_target), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .pc(pc), .instout(instout), .branch_adder_out(branch_adder_out),
        .valid(valid), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: architectural state of the fetch stage.
    logic [15:0] m_mem [256];
    logic [15:0] m_pc, m_inst, m_bao, m_cnt;
    logic        m_valid;

    typedef struct {
        bit          rst, stl, br;
        logic [15:0] tgt;
        bit          we;
        logic [7:0]  wa;
        logic [15:0] wd;
        logic [15:0] e_pc, e_inst, e_bao;
        bit          e_valid;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(bit r, bit s, bit p, logic [15:0] t, bit we,
                               logic [7:0] wa, logic [15:0] wd, logic [15:0] ep,
                               logic [15:0] ei, logic [15:0] eb, bit ev,
                               logic [15:0] ec);
        vec_t x;
        x.rst = r; x.stl = s; x.br = p; x.tgt = t; x.we = we; x.wa = wa; x.wd = wd;
        x.e_pc = ep; x.e_inst = ei; x.e_bao = eb; x.e_valid = ev; x.e_cnt = ec;
        return x;
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_pc = 0; m_inst = 0; m_bao = 0; m_valid = 0; m_cnt = 0;
        end else if (pcsrc) begin
            m_pc = branch_target; m_inst = 0; m_bao = 0; m_valid = 0;
        end else if (!stall) begin
            m_inst  = m_mem[m_pc % 256];
            m_pc    = m_pc + 16'd1;
            m_bao   = m_pc;
            m_valid = 1;
            if (m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        if (imem_we) m_mem[imem_waddr] = imem_wdata;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit r, bit s, bit p, logic [15:0] t, bit we,
                         logic [7:0] wa, logic [15:0] wd);
        reset = r; stall = s; pcsrc = p; branch_target = t;
        imem_we = we; imem_waddr = wa; imem_wdata = wd;
    endtask

    task automatic check_model(string tag);
        check({tag, ".pc"},    pc,               m_pc);
        check({tag, ".inst"},  instout,          m_inst);
        check({tag, ".bao"},   branch_adder_out, m_bao);
        check({tag, ".valid"}, {15'd0, valid},   {15'd0, m_valid});
        check({tag, ".cnt"},   fetch_count,      m_cnt);
    endtask

    initial begin
        logic [15:0] wd;
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) m_mem[i] = 16'hxxxx;

        // Preload the whole memory while held in reset.
        for (int i = 0; i < 256; i++) begin
            case (i)
                0:       wd = 16'h0531;
                1:       wd = 16'h1F22;
                2:       wd = 16'h1F33;
                3:       wd = 16'h1343;
                5:       wd = 16'hD7E7;
                16:      wd = 16'h1616;
                255:     wd = 16'hABCD;
                default: wd = 16'($urandom);
            endcase
            drive(1, 0, 0, 0, 1, 8'(i), wd);
            step();
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        check("reset.pc",    pc,               16'h0000);
        check("reset.inst",  instout,          16'h0000);
        check("reset.bao",   branch_adder_out, 16'h0000);
        check("reset.valid", {15'd0, valid},   16'h0000);
        check("reset.cnt",   fetch_count,      16'h0000);

        //              rst stl br tgt      we wa    wd        pc       inst     bao     v  cnt
        vq.push_back(v(0, 0, 0, 16'h0000, 0, 8'h00, 16'h0000, 16'h0001, 16'h0531, 16'h0001, 1, 16'd1));
        vq.push_back(v(0, 0, 0, 16'h0000, 0, 8'h00, 16'h0000, 16'h0002, 16'h1F22, 16'h0002, 1, 16'd2));
        vq.push_back(v(0, 0, 0, 16'h0000, 0, 8'h00, 16'h0000, 16'h0003, 16'h1F33, 16'h0003, 1, 16'd3));
        vq.push_back(v(0, 0, 0, 16'h0000, 0, 8'h00, 16'h0000, 16'h0004, 16'h1343, 16'h0004, 1, 16'd4));
        vq.push_back(v(1, 0, 0, 16'h0000, 0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0));
        vq.push_back(v(0, 0, 0, 16'h0000, 0, 8'h00, 16'h0000, 16'h0001, 16'h0531, 16'h0001, 1, 16'd1));
        vq.push_back(v(0, 0, 0, 16'h0000, 0, 8'h00, 16'h0000, 16'h0002, 16'h1F22, 16'h0002, 1, 16'd2));
        vq.push_back(v(0, 1, 0, 16'h0000, 0, 8'h00, 16'h0000, 16'h0002, 16'h1F22, 16'h0002, 1, 16'd2));
        vq.push_back(v(0, 1, 0, 16'h0000, 0, 8'h00, 16'h0000, 16'h0002, 16'h1F22, 16'h0002, 1, 16'd2));
        vq.push_back(v(0, 1, 0, 16'h0000, 0, 8'h00, 16'h0000, 16'h0002, 16'h1F22, 16'h0002, 1, 16'd2));
        vq.push_back(v(0, 0, 0, 16'h0000, 0, 8'h00, 16'h0000, 16'h0003, 16'h1F33, 16'h0003, 1, 16'd3));
        vq.push_back(v(1, 1, 1, 16'h0040, 0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0));
        vq.push_back(v(0, 0, 0, 16'h0000, 0, 8'h00, 16'h0000, 16'h0001, 16'h0531, 16'h0001, 1, 16'd1));
        vq.push_back(v(0, 1, 1, 16'h0010, 0, 8'h00, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 0, 16'd1));
        vq.push_back(v(0, 0, 0, 16'h0000, 0, 8'h00, 16'h0000, 16'h0011, 16'h1616, 16'h0011, 1, 16'd2));
        vq.push_back(v(0, 0, 1, 16'h0005, 0, 8'h00, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 0, 16'd2));
        vq.push_back(v(0, 0, 0, 16'h0000, 1, 8'h05, 16'hF4E7, 16'h0006, 16'hD7E7, 16'h0006, 1, 16'd3));
        vq.push_back(v(0, 0, 1, 16'h0005, 0, 8'h00, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 0, 16'd3));
        vq.push_back(v(0, 0, 0, 16'h0000, 0, 8'h00, 16'h0000, 16'h0006, 16'hF4E7, 16'h0006, 1, 16'd4));
        vq.push_back(v(0, 0, 1, 16'hFFFF, 0, 8'h00, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 0, 16'd4));
        vq.push_back(v(0, 0, 0, 16'h0000, 0, 8'h00, 16'h0000, 16'h0000, 16'hABCD, 16'h0000, 1, 16'd5));
        vq.push_back(v(0, 0, 0, 16'h0000, 0, 8'h00, 16'h0000, 16'h0001, 16'h0531, 16'h0001, 1, 16'd6));
        vq.push_back(v(0, 0, 1, 16'h0103, 0, 8'h00, 16'h0000, 16'h0103, 16'h0000, 16'h0000, 0, 16'd6));
        vq.push_back(v(0, 0, 0, 16'h0000, 0, 8'h00, 16'h0000, 16'h0104, 16'h1343, 16'h0104, 1, 16'd7));

        foreach (vq[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(vq[i].rst, vq[i].stl, vq[i].br, vq[i].tgt, vq[i].we, vq[i].wa, vq[i].wd);
            step();
            check({t, ".pc"},    pc,               vq[i].e_pc);
            check({t, ".inst"},  instout,          vq[i].e_inst);
            check({t, ".bao"},   branch_adder_out, vq[i].e_bao);
            check({t, ".valid"}, {15'd0, valid},   {15'd0, vq[i].e_valid});
            check({t, ".cnt"},   fetch_count,      vq[i].e_cnt);
        end

        // Counter saturation: jump the count near the top, then keep fetching.
        drive(0, 0, 0, 0, 0, 0, 0);
        force dut.r_fcnt_q = 16'hFFFE;
        #1;
        release dut.r_fcnt_q;
        m_cnt = 16'hFFFE;
        step();
        check("sat.inc",   fetch_count, 16'hFFFF);
        step();
        check("sat.hold1", fetch_count, 16'hFFFF);
        step();
        check("sat.hold2", fetch_count, 16'hFFFF);
        drive(0, 1, 0, 0, 0, 0, 0);
        step();
        check("sat.stall", fetch_count, 16'hFFFF);

        // Randomized traffic against the reference model.
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        check_model("rnd.rst");
        for (int i = 0; i < 600; i++) begin
            logic [15:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 300));
            if (($urandom_range(0, 7) == 0)) tgt = 16'hFFFF - 16'($urandom_range(0, 2));
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, tgt, $urandom_range(0, 2) == 0,
                  8'($urandom), 16'($urandom));
            step();
            check_model($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
